// File: rtl/bcd_digit_sequencer_if.sv
// Handshake and result bundle for the BCD digit sequencer.
// Start/Value in from the master; Busy/Done/Digit0..3/Blank back.
interface bcd_digit_sequencer_if;
  logic        Start;
  logic [12:0] Value;
  logic        Busy;
  logic        Done;
  logic [3:0]  Digit0;
  logic [3:0]  Digit1;
  logic [3:0]  Digit2;
  logic [3:0]  Digit3;
  logic [3:0]  Blank;

  modport master (
    output Start, Value,
    input  Busy, Done, Digit0, Digit1,
    input  Digit2, Digit3, Blank
  );

  modport slave (
    input  Start, Value,
    output Busy, Done, Digit0, Digit1,
    output Digit2, Digit3, Blank
  );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// Binary (13-bit) to 4-digit BCD by repeated divide-by-ten.
// Ports: clk, reset_n (async low), bus (slave: Start/Value in,
// Busy/Done/Digit0..3/Blank out, all outputs registered state).
module bcd_digit_sequencer (
  input logic                   clk,
  input logic                   reset_n,
  bcd_digit_sequencer_if.slave  bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [12:0]      work_q, work_d;
  logic [1:0]       index_q, index_d;
  logic [3:0][3:0]  scratch_q, scratch_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       blank_q, blank_d;

  // Single shared divide-by-ten datapath on the work register.
  logic [12:0] quo_w;
  logic [3:0]  rem_w;
  assign quo_w = work_q / 13'd10;
  assign rem_w = 4'(work_q - 13'(quo_w * 13'd10));

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    index_d   = index_q;
    scratch_d = scratch_q;
    digit_d   = digit_q;
    blank_d   = blank_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (bus.Start) begin
          work_d  = bus.Value;
          index_d = 2'd0;
          state_d = CONVERT;
        end
      end
      state_q == CONVERT: begin
        scratch_d[index_q] = rem_w;
        work_d  = quo_w;
        index_d = index_q + 2'd1;
        if (index_q == 2'd3) begin
          state_d = DONE;
          // Publish all digits at once, including this step's.
          digit_d    = scratch_d;
          blank_d[3] = (scratch_d[3] == 4'd0);
          blank_d[2] = blank_d[3] && (scratch_d[2] == 4'd0);
          blank_d[1] = blank_d[2] && (scratch_d[1] == 4'd0);
          blank_d[0] = 1'b0;
        end
      end
      state_q == DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      index_q   <= '0;
      scratch_q <= '0;
      digit_q   <= '0;
      blank_q   <= 4'b1110;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      index_q   <= index_d;
      scratch_q <= scratch_d;
      digit_q   <= digit_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.Busy   = (state_q == CONVERT);
  assign bus.Done   = (state_q == DONE);
  assign bus.Digit0 = digit_q[0];
  assign bus.Digit1 = digit_q[1];
  assign bus.Digit2 = digit_q[2];
  assign bus.Digit3 = digit_q[3];
  assign bus.Blank  = blank_q;
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Scoreboard bench for bcd_digit_sequencer.
// Expected digits/blank queued at Start, compared on Done.
module tb_bcd_digit_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_sequencer_if bus();

  bcd_digit_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [19:0] sb_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // {Digit3,Digit2,Digit1,Digit0,Blank}
  function automatic logic [19:0] exp_of(input int v);
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] bl;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'(v / 1000);
    bl = {v < 1000, v < 100, v < 10, 1'b0};
    return {d3, d2, d1, d0, bl};
  endfunction

  function automatic logic [19:0] outs();
    return {bus.Digit3, bus.Digit2, bus.Digit1,
            bus.Digit0, bus.Blank};
  endfunction

  always @(negedge clk) begin : mon
    logic [19:0] e;
    if (bus.Done) begin
      chk("busy_done", 32'(bus.Busy), 32'd0);
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result", 32'(outs()), 32'(e));
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.Done && n < 20);
    if (!bus.Done) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int v);
    int n;
    @(negedge clk);
    bus.Value = 13'(v);
    bus.Start = 1'b1;
    sb_q.push_back(exp_of(v));
    @(posedge clk);
    #1 bus.Start = 1'b0;
    wait_done(n);
    chk("run_lat", 32'(n), 32'd5);
  endtask

  initial begin
    int n;
    bus.Start = 1'b0;
    bus.Value = '0;

    #12;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_out", 32'(outs()), 32'h0000E);

    // 1234 right after reset release, cycle-exact latency
    @(negedge clk);
    reset_n = 1'b1;
    bus.Value = 13'd1234;
    bus.Start = 1'b1;
    sb_q.push_back(exp_of(1234));
    @(posedge clk);
    #1 bus.Start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("lat_busy", 32'(bus.Busy), 32'(i <= 4));
      chk("lat_done", 32'(bus.Done), 32'(i == 5));
      if (i < 5) chk("hold_pre", 32'(outs()), 32'h0000E);
    end
    chk("d1234", 32'(outs()), 32'h12340);

    run(8191);
    chk("d8191", 32'(outs()), 32'h81910);
    run(0);
    chk("d0", 32'(outs()), 32'h0000E);
    run(7);
    chk("d7", 32'(outs()), 32'h0007E);
    run(305);
    chk("d305", 32'(outs()), 32'h03058);

    // Start/Value toggled during Busy and Done are ignored
    @(negedge clk);
    bus.Value = 13'd1234;
    bus.Start = 1'b1;
    sb_q.push_back(exp_of(1234));
    @(posedge clk);
    #1 bus.Start = 1'b0;
    @(negedge clk);
    bus.Value = 13'd999;
    bus.Start = 1'b1;
    wait_done(n);
    chk("ign_lat", 32'(n), 32'd4);
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ign_res", 32'(outs()), 32'h12340);
    chk("ign_idle", 32'(bus.Busy), 32'd0);

    // Start held high: back-to-back every 6 cycles
    @(negedge clk);
    bus.Value = 13'd100;
    bus.Start = 1'b1;
    sb_q.push_back(exp_of(100));
    wait_done(n);
    chk("cont_first", 32'(n), 32'd5);
    for (int i = 1; i <= 3; i++) begin
      bus.Value = 13'(100 + i * 1111);
      sb_q.push_back(exp_of(100 + i * 1111));
      wait_done(n);
      chk("cont_period", 32'(n), 32'd6);
    end
    bus.Start = 1'b0;

    // Reset in the 2nd CONVERT cycle aborts 4321
    run(1234);
    @(negedge clk);
    bus.Value = 13'd4321;
    bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_pre", 32'(bus.Busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_out", 32'(outs()), 32'h0000E);
    repeat (3) @(negedge clk);
    chk("abort_hold", 32'(outs()), 32'h0000E);

    // First Start after release accepted at the next edge
    reset_n = 1'b1;
    bus.Value = 13'd42;
    bus.Start = 1'b1;
    sb_q.push_back(exp_of(42));
    @(posedge clk);
    #1 bus.Start = 1'b0;
    wait_done(n);
    chk("post_rst_lat", 32'(n), 32'd5);
    chk("d42", 32'(outs()), 32'h0042C);

    // Exhaustive sweep with Start held high
    @(negedge clk);
    bus.Value = 13'd0;
    bus.Start = 1'b1;
    sb_q.push_back(exp_of(0));
    wait_done(n);
    for (int v = 1; v <= 8191; v++) begin
      bus.Value = 13'(v);
      sb_q.push_back(exp_of(v));
      wait_done(n);
    end
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
